// File: rtl/windowed_reg_file_if.sv
// Bus bundle for windowed_reg_file. Clock and reset are plain ports on the module.
// master drives the requests and slave is the register file.
interface windowed_reg_file_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int NUM_WND = 4
);
  localparam int CW = $clog2(NUM_WND);

  // There is no valid/ready pairing. Every input is level-sampled on each rising
  // Clock edge, the file never applies backpressure, and the read outputs follow
  // the read indices combinationally.
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_Wire;
  logic [DATA_W-1:0] Write_Data;
  logic [ADDR_W-1:0] Read1_Wire;
  logic [ADDR_W-1:0] Read2_Wire;
  logic [DATA_W-1:0] Read_Data1;
  logic [DATA_W-1:0] Read_Data2;
  logic              Save;
  logic              Restore;
  logic [CW-1:0]     Cwp;
  logic [CW-1:0]     Depth;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output RegWrite, Write_Wire, Write_Data, Read1_Wire, Read2_Wire, Save, Restore,
    input  Read_Data1, Read_Data2, Cwp, Depth, Overflow, Underflow
  );

  modport slave (
    input  RegWrite, Write_Wire, Write_Data, Read1_Wire, Read2_Wire, Save, Restore,
    output Read_Data1, Read_Data2, Cwp, Depth, Overflow, Underflow
  );
endinterface

// File: rtl/windowed_reg_file.sv
// Register file with overlapping windows. Logical index i maps to the physical
// register (Cwp*STEP + i) mod PHYS. Define RF_BYPASS_EN to forward write data to reads.
module windowed_reg_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int NUM_WND = 4,
  parameter int STEP    = 2
) (
  input logic                  Clock,
  input logic                  Rst,
  windowed_reg_file_if.slave   bus
);
  localparam int PHYS = NUM_WND * STEP;
  localparam int PW   = $clog2(PHYS);
  localparam int CW   = $clog2(NUM_WND);
  localparam logic [CW-1:0] MAX_DEPTH = CW'(NUM_WND - 1);

  // The index can exceed 2*PHYS when 2**ADDR_W is large against STEP, so a single
  // subtract would not be enough. A real modulo by the constant PHYS is used instead.
  function automatic logic [PW-1:0] phys_idx(input logic [CW-1:0] wnd,
                                             input logic [ADDR_W-1:0] idx);
    int sum;
    sum = int'(wnd) * STEP + int'(idx);
    return PW'(sum % PHYS);
  endfunction

  logic [DATA_W-1:0] mem [PHYS];
  logic [CW-1:0]     cwp_q, cwp_d;
  logic [CW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [PW-1:0]     wr_idx, rd1_idx, rd2_idx;
  logic [DATA_W-1:0] rd1, rd2;

  assign wr_idx  = phys_idx(cwp_q, bus.Write_Wire);
  assign rd1_idx = phys_idx(cwp_q, bus.Read1_Wire);
  assign rd2_idx = phys_idx(cwp_q, bus.Read2_Wire);

  // The write uses the window that is current before the edge. A Save or Restore
  // on the same edge does not change the target of that write.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < PHYS; i++) mem[i] <= '0;
    end else if (bus.RegWrite) begin
      mem[wr_idx] <= bus.Write_Data;
    end
  end

  always_comb begin
    cwp_d   = cwp_q;
    depth_d = depth_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.Save && !bus.Restore) begin
      if (depth_q == MAX_DEPTH) begin
        ovf_d = 1'b1;
      end else begin
        cwp_d   = cwp_q + 1'b1;
        depth_d = depth_q + 1'b1;
      end
    end else if (bus.Restore && !bus.Save) begin
      if (depth_q == '0) begin
        unf_d = 1'b1;
      end else begin
        cwp_d   = cwp_q - 1'b1;
        depth_d = depth_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      cwp_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cwp_q   <= cwp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    rd1 = mem[rd1_idx];
    rd2 = mem[rd2_idx];
`ifdef RF_BYPASS_EN
    if (bus.RegWrite && (rd1_idx == wr_idx)) rd1 = bus.Write_Data;
    if (bus.RegWrite && (rd2_idx == wr_idx)) rd2 = bus.Write_Data;
`endif
  end

  assign bus.Read_Data1 = rd1;
  assign bus.Read_Data2 = rd2;
  assign bus.Cwp        = cwp_q;
  assign bus.Depth      = depth_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Underflow  = unf_q;
endmodule

// File: doc/windowed_reg_file.md
WINDOWED_REG_FILE -- requirements
Module: windowed_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter ADDR_W, default 2, logical register index width; window size is 2**ADDR_W.
REQ-003 SHALL have parameter NUM_WND, default 4, number of windows; power of two, at least 2.
REQ-004 SHALL have parameter STEP, default 2, physical offset between adjacent windows; 1 <= STEP <= 2**ADDR_W; overlap is 2**ADDR_W-STEP.
REQ-005 SHALL have ports: Clock  in  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: Rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: RegWrite  in  1  write enable.
REQ-008 SHALL have ports: Write_Wire  in  ADDR_W  logical write index; Write_Data  in  DATA_W  write data.
REQ-009 SHALL have ports: Read1_Wire, Read2_Wire  in  ADDR_W  logical read indices.
REQ-010 SHALL have ports: Read_Data1, Read_Data2  out  DATA_W  read data.
REQ-011 SHALL have ports: Save, Restore  in  1  window advance / retreat request.
REQ-012 SHALL have ports: Cwp  out  log2(NUM_WND)  current window pointer.
REQ-013 SHALL have ports: Depth  out  log2(NUM_WND)  windows in use beyond the base window.
REQ-014 SHALL have ports: Overflow, Underflow  out  1  one-cycle trap pulses.

Function
REQ-015 Physical storage SHALL be PHYS = NUM_WND*STEP registers of DATA_W bits.
REQ-016 Physical index SHALL be (Cwp*STEP + logical index) mod PHYS for all reads and writes; wrap-around past PHYS-1 is to 0.
REQ-017 Reads SHALL be combinational from current Cwp; zero latency.
REQ-018 Write SHALL occur on rising Clock when RegWrite=1, using Cwp value before that edge.
REQ-019 Save alone with Depth < NUM_WND-1: next cycle Cwp=Cwp+1 mod NUM_WND, Depth=Depth+1.
REQ-020 Save alone with Depth = NUM_WND-1: Cwp and Depth unchanged, Overflow=1 for exactly the next cycle.
REQ-021 Restore alone with Depth > 0: next cycle Cwp=Cwp-1 mod NUM_WND, Depth=Depth-1.
REQ-022 Restore alone with Depth = 0: Cwp and Depth unchanged, Underflow=1 for exactly the next cycle.
REQ-023 Save and Restore both 1: no change to Cwp or Depth, no trap pulse.
REQ-024 RegWrite coincident with Save/Restore: write lands in the old window; window change takes effect the same edge.
REQ-025 Overflow and Underflow SHALL be registered, never both 1, and deassert after one cycle unless re-triggered.

Reset
REQ-026 Rst=0 SHALL asynchronously clear all PHYS registers to 0, Cwp=0, Depth=0, Overflow=0, Underflow=0.
REQ-027 Reset asserted mid-operation SHALL discard any pending write or window change of that cycle.
REQ-028 After Rst deasserts, first effective edge SHALL behave as from Depth=0, Cwp=0.

Configuration
REQ-029 Macro RF_BYPASS_EN defined: when RegWrite=1 and a read port's physical index equals the write physical index, that Read_Data SHALL return Write_Data combinationally.
REQ-030 RF_BYPASS_EN undefined: Read_Data SHALL return the stored value; the new value is visible the cycle after the write.

Verification
REQ-031 Reset, then read all indices in window 0 -> all Read_Data = 0, Cwp=0, Depth=0.
REQ-032 Write 0x1234 to logical 2 in window 0, Save, read logical 0 -> 0x1234 (overlap with defaults).
REQ-033 Four Saves from reset (defaults) -> Cwp=3, Depth=3 after three; fourth gives Overflow=1 one cycle, Cwp stays 3.
REQ-034 Restore from reset -> Underflow=1 one cycle, Cwp=0; Save+Restore same cycle -> no change, no pulses.
REQ-035 At Cwp=3 write 0xBEEF to logical 2 -> read logical 0 at Cwp=0 (after Restores) returns 0xBEEF (wrap to physical 0).
REQ-036 Write 0x00AA and read same index same cycle -> 0x00AA with RF_BYPASS_EN, old value without; Rst=0 mid-Save -> Cwp=0, Depth=0 immediately.
